// File: rtl/fetch_unit.sv
// Purpose : instruction fetch sequencer (IDLE/FETCH/HALT) driving a 4-bit PC
//           into instruction memory and registering the returned word in IR.
// Latency : one clock; INS for PC=n is captured into IR on the edge that ends PC=n.
// Backpressure: STALL freezes PC, IR, IR_VALID and state; JMP is ignored while stalled.
//
// Ports:
//   CLK       in   1  system clock, rising-edge
//   RST       in   1  asynchronous active-high reset
//   EN        in   1  run enable; 0 parks fetch in IDLE
//   STALL     in   1  downstream hold
//   JMP       in   1  load JMP_ADDR into PC instead of incrementing
//   JMP_ADDR  in   4  jump target
//   INS       in  16  instruction memory data for the current PC (same cycle)
//   PC        out  4  registered fetch address
//   IR        out 16  registered instruction
//   IR_VALID  out  1  IR holds a newly fetched instruction this cycle
//   HALTED    out  1  HALT state has been entered
module fetch_unit #(
  parameter logic [3:0] RESET_PC = 4'h0,
  parameter logic [7:0] HALT_OPC = 8'h03
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        STALL,
  input  logic        JMP,
  input  logic [3:0]  JMP_ADDR,
  input  logic [15:0] INS,
  output logic [3:0]  PC,
  output logic [15:0] IR,
  output logic        IR_VALID,
  output logic        HALTED
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic        halted_q, halted_d;

  logic        is_halt;
  assign is_halt = (INS[15:8] == HALT_OPC);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;

    unique case (state_q)
      S_IDLE: begin
        ir_valid_d = 1'b0;
        if (EN) state_d = S_FETCH;
      end

      S_FETCH: begin
        // Priority: STALL (hold all, even with EN=0) > EN=0 (park) > HALT > JMP > increment.
        if (!STALL) begin
          if (!EN) begin
            state_d    = S_IDLE;
            ir_valid_d = 1'b0;
          end else begin
            ir_d       = INS;
            ir_valid_d = 1'b1;
            if (is_halt) begin
              // PC stays on the HALT word; a concurrent JMP is dropped.
              state_d  = S_HALT;
              halted_d = 1'b1;
            end else if (JMP) begin
              pc_d = JMP_ADDR;
            end else begin
              pc_d = pc_q + 4'd1;  // wraps F->0 naturally
            end
          end
        end
      end

      S_HALT: begin
        // Only RST leaves HALT; all run controls are ignored here.
        ir_valid_d = 1'b0;
        halted_d   = 1'b1;
      end

      default: begin
        state_d    = S_IDLE;
        ir_valid_d = 1'b0;
      end
    endcase
  end

  assign PC       = pc_q;
  assign IR       = ir_q;
  assign IR_VALID = ir_valid_q;
  assign HALTED   = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        en;
  logic        stall;
  logic        jmp;
  logic [3:0]  jmp_addr;
  logic [15:0] ins;
  logic [3:0]  pc;
  logic [15:0] ir;
  logic        ir_valid;
  logic        halted;

  // second instance with RESET_PC=E for the wrap check
  logic [15:0] ins2;
  logic [3:0]  pc2;
  logic [15:0] ir2;
  logic        ir_valid2;
  logic        halted2;

  logic [15:0] mem [16];

  int pass_cnt = 0;
  int total_cnt = 0;

  fetch_unit dut (
    .CLK(clk), .RST(rst), .EN(en), .STALL(stall), .JMP(jmp), .JMP_ADDR(jmp_addr),
    .INS(ins), .PC(pc), .IR(ir), .IR_VALID(ir_valid), .HALTED(halted)
  );

  fetch_unit #(.RESET_PC(4'hE)) dut_wrap (
    .CLK(clk), .RST(rst), .EN(en), .STALL(stall), .JMP(jmp), .JMP_ADDR(jmp_addr),
    .INS(ins2), .PC(pc2), .IR(ir2), .IR_VALID(ir_valid2), .HALTED(halted2)
  );

  assign ins  = mem[pc];
  assign ins2 = {12'h020, pc2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one rising edge, then settle before sampling/driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0; stall = 1'b0; jmp = 1'b0; jmp_addr = 4'h0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 16; i++) mem[i] = 16'h0200 + 16'(i);
    en = 1'b0; stall = 1'b0; jmp = 1'b0; jmp_addr = 4'h0;
    rst = 1'b1;
    #3;
    total_cnt++;
    if ({pc, ir, ir_valid, halted} !== {4'h0, 16'h0000, 1'b0, 1'b0})
      $display("FAIL reset_state got pc=%h ir=%h v=%b h=%b want pc=0 ir=0000 v=0 h=0", pc, ir, ir_valid, halted);
    else pass_cnt++;
    total_cnt++;
    if (pc2 !== 4'hE) $display("FAIL reset_pc_param got %h want e", pc2);
    else pass_cnt++;
    rst = 1'b0;
    step(); step();
    total_cnt++;
    if ({pc, ir_valid} !== {4'h0, 1'b0})
      $display("FAIL idle_no_en got pc=%h v=%b want pc=0 v=0", pc, ir_valid);
    else pass_cnt++;
  endtask

  task automatic test_sequential();
    en = 1'b1;
    step();  // IDLE -> FETCH
    total_cnt++;
    if ({pc, ir, ir_valid} !== {4'h0, 16'h0000, 1'b0})
      $display("FAIL seq_first_edge got pc=%h ir=%h v=%b want pc=0 ir=0000 v=0", pc, ir, ir_valid);
    else pass_cnt++;
    for (int k = 1; k <= 6; k++) begin
      step();
      total_cnt++;
      if ({pc, ir, ir_valid} !== {4'(k), 16'h0200 + 16'(k - 1), 1'b1})
        $display("FAIL seq_step%0d got pc=%h ir=%h v=%b want pc=%h ir=%h v=1",
                 k, pc, ir, ir_valid, 4'(k), 16'h0200 + 16'(k - 1));
      else pass_cnt++;
      if (k <= 3) begin
        total_cnt++;
        if ({pc2, ir_valid2} !== {4'(14 + k), 1'b1})
          $display("FAIL wrap_step%0d got pc=%h v=%b want pc=%h v=1", k, pc2, ir_valid2, 4'(14 + k));
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_pause_and_async_reset();
    do_reset();
    en = 1'b1;
    step();
    for (int k = 0; k < 4; k++) step();
    total_cnt++;
    if ({pc, ir} !== {4'h4, 16'h0203})
      $display("FAIL pause_setup got pc=%h ir=%h want pc=4 ir=0203", pc, ir);
    else pass_cnt++;
    en = 1'b0;
    step(); step();
    total_cnt++;
    if ({pc, ir, ir_valid} !== {4'h4, 16'h0203, 1'b0})
      $display("FAIL pause_idle got pc=%h ir=%h v=%b want pc=4 ir=0203 v=0", pc, ir, ir_valid);
    else pass_cnt++;
    en = 1'b1;
    step();  // back to FETCH
    total_cnt++;
    if ({pc, ir_valid} !== {4'h4, 1'b0})
      $display("FAIL resume_transition got pc=%h v=%b want pc=4 v=0", pc, ir_valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({pc, ir, ir_valid} !== {4'h5, 16'h0204, 1'b1})
      $display("FAIL resume_fetch got pc=%h ir=%h v=%b want pc=5 ir=0204 v=1", pc, ir, ir_valid);
    else pass_cnt++;
    // async reset between edges with PC=5 in FETCH
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({pc, ir, ir_valid, halted} !== {4'h0, 16'h0000, 1'b0, 1'b0})
      $display("FAIL async_reset_run got pc=%h ir=%h v=%b h=%b want pc=0 ir=0000 v=0 h=0", pc, ir, ir_valid, halted);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_jump_stall();
    do_reset();
    en = 1'b1;
    step();
    for (int k = 0; k < 3; k++) step();
    jmp = 1'b1; jmp_addr = 4'h9; stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      total_cnt++;
      if ({pc, ir, ir_valid} !== {4'h3, 16'h0202, 1'b1})
        $display("FAIL stall_hold%0d got pc=%h ir=%h v=%b want pc=3 ir=0202 v=1", k, pc, ir, ir_valid);
      else pass_cnt++;
    end
    stall = 1'b0;
    step();
    total_cnt++;
    if ({pc, ir, ir_valid} !== {4'h9, 16'h0203, 1'b1})
      $display("FAIL jump_after_stall got pc=%h ir=%h v=%b want pc=9 ir=0203 v=1", pc, ir, ir_valid);
    else pass_cnt++;
    step();  // jump to the current PC refetches it
    total_cnt++;
    if ({pc, ir} !== {4'h9, 16'h0209})
      $display("FAIL jump_same_addr got pc=%h ir=%h want pc=9 ir=0209", pc, ir);
    else pass_cnt++;
    jmp = 1'b0;
    // EN=0 while stalled: stall wins
    en = 1'b0; stall = 1'b1;
    step();
    total_cnt++;
    if ({pc, ir_valid} !== {4'h9, 1'b1})
      $display("FAIL stall_over_en got pc=%h v=%b want pc=9 v=1", pc, ir_valid);
    else pass_cnt++;
    stall = 1'b0;
    step();
    total_cnt++;
    if ({pc, ir, ir_valid} !== {4'h9, 16'h0209, 1'b0})
      $display("FAIL en_drop_idle got pc=%h ir=%h v=%b want pc=9 ir=0209 v=0", pc, ir, ir_valid);
    else pass_cnt++;
  endtask

  task automatic test_halt();
    do_reset();
    mem[7] = 16'h0300;
    en = 1'b1;
    step();
    for (int k = 0; k < 7; k++) step();
    total_cnt++;
    if ({pc, ir} !== {4'h7, 16'h0206})
      $display("FAIL halt_setup got pc=%h ir=%h want pc=7 ir=0206", pc, ir);
    else pass_cnt++;
    jmp = 1'b1; jmp_addr = 4'h2;
    step();
    total_cnt++;
    if ({pc, ir, ir_valid, halted} !== {4'h7, 16'h0300, 1'b1, 1'b1})
      $display("FAIL halt_entry got pc=%h ir=%h v=%b h=%b want pc=7 ir=0300 v=1 h=1", pc, ir, ir_valid, halted);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({pc, ir, ir_valid, halted} !== {4'h7, 16'h0300, 1'b0, 1'b1})
      $display("FAIL halt_after got pc=%h ir=%h v=%b h=%b want pc=7 ir=0300 v=0 h=1", pc, ir, ir_valid, halted);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      en = ~en; jmp = ~jmp; stall = k[0];
      jmp_addr = 4'(k);
      step();
      total_cnt++;
      if ({pc, ir, ir_valid, halted} !== {4'h7, 16'h0300, 1'b0, 1'b1})
        $display("FAIL halt_sticky%0d got pc=%h ir=%h v=%b h=%b want pc=7 ir=0300 v=0 h=1", k, pc, ir, ir_valid, halted);
      else pass_cnt++;
    end
    #2;
    rst = 1'b1;
    #1;
    total_cnt++;
    if ({pc, ir, ir_valid, halted} !== {4'h0, 16'h0000, 1'b0, 1'b0})
      $display("FAIL async_reset_halt got pc=%h ir=%h v=%b h=%b want pc=0 ir=0000 v=0 h=0", pc, ir, ir_valid, halted);
    else pass_cnt++;
    rst = 1'b0;
    mem[7] = 16'h0207;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; stall = 1'b0; jmp = 1'b0; jmp_addr = 4'h0;
    test_reset();
    test_sequential();
    test_pause_and_async_reset();
    test_jump_stall();
    test_halt();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
